// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   op_valid, md_op      E-stage valid and mdOp code (1 mult .. 8 mflo)
//   rs_val, rt_val       forwarded operands
//   flush                exception/eret: blocks acceptance this cycle
//   start                comb: mult/multu/div/divu accepted this cycle
//   busy                 registered: operation in flight
//   rd_data              comb: HI for mfhi, LO for mflo, else 0
//   hi, lo               HI/LO registers
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned PROD_W  = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             complete_c;
  logic             accept;
  logic             is_mult;
  logic [WIDTH-1:0] pend_hi_q, pend_lo_q;
  logic             pend_we_q;

  // Acceptance and issue decode
  assign accept  = op_valid & ~flush & ~busy;
  assign is_mult = (md_op == OP_MULT) | (md_op == OP_MULTU);
  assign start   = accept & (is_mult | (md_op == OP_DIV) | (md_op == OP_DIVU));
  assign busy    = (state_q == RUN);

  // Move-from read port: reflects the current registers, ignores busy
  always_comb begin
    rd_data = '0;
    if (md_op == OP_MFHI)      rd_data = hi;
    else if (md_op == OP_MFLO) rd_data = lo;
  end

  // Result computation, captured into the pending registers on start
  logic signed [PROD_W-1:0] prod_s;
  logic        [PROD_W-1:0] prod_u;
  logic                     div_signed;
  logic        [WIDTH-1:0]  dvd_mag, dvs_mag, dvs_safe, q_mag, r_mag, quot, rem;
  logic        [WIDTH-1:0]  res_hi, res_lo;
  logic                     res_we;

  always_comb begin
    prod_s     = PROD_W'($signed(rs_val)) * PROD_W'($signed(rt_val));
    prod_u     = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
    div_signed = (md_op == OP_DIV);
    // Signed divide on magnitudes; INT_MIN/-1 wraps back to INT_MIN with rem 0
    dvd_mag    = (div_signed & rs_val[WIDTH-1]) ? (~rs_val + WIDTH'(1)) : rs_val;
    dvs_mag    = (div_signed & rt_val[WIDTH-1]) ? (~rt_val + WIDTH'(1)) : rt_val;
    dvs_safe   = (rt_val == '0) ? WIDTH'(1) : dvs_mag;
    q_mag      = dvd_mag / dvs_safe;
    r_mag      = dvd_mag % dvs_safe;
    quot       = (div_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1])) ? (~q_mag + WIDTH'(1)) : q_mag;
    rem        = (div_signed & rs_val[WIDTH-1]) ? (~r_mag + WIDTH'(1)) : r_mag;
    res_hi     = rem;
    res_lo     = quot;
    res_we     = (rt_val != '0);
    if (md_op == OP_MULT) begin
      res_hi = WIDTH'(prod_s >>> WIDTH);
      res_lo = WIDTH'(prod_s);
      res_we = 1'b1;
    end else if (md_op == OP_MULTU) begin
      res_hi = WIDTH'(prod_u >> WIDTH);
      res_lo = WIDTH'(prod_u);
      res_we = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: count down, complete on the edge where the counter is 1
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    complete_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          complete_c = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // HI/LO and pending result; completion and moves are exclusive via busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi        <= '0;
      lo        <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      if (start) begin
        pend_hi_q <= res_hi;
        pend_lo_q <= res_lo;
        pend_we_q <= res_we;
      end
      if (complete_c) begin
        if (pend_we_q) begin
          hi <= pend_hi_q;
          lo <= pend_lo_q;
        end
      end else if (accept) begin
        if (md_op == OP_MTHI) hi <= rs_val;
        if (md_op == OP_MTLO) lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (WIDTH 32, 5/10 cycle latency).
module tb_md_unit;

  logic        clk;
  logic        reset_n;
  logic        op_valid;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        start;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .start(start),
    .busy(busy), .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at a negedge, then count busy cycles (bounded). Returns at the
  // first negedge with busy low, inputs idle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic started, output int cycles);
    @(negedge clk);
    op_valid = 1'b1; md_op = op; rs_val = a; rt_val = b;
    #1 started = start;
    @(negedge clk);
    op_valid = 1'b0; md_op = 4'd0;
    cycles = 0;
    while (busy && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // Single-cycle non-busy op (mthi/mtlo)
  task automatic one_op(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    op_valid = 1'b1; md_op = op; rs_val = a;
    @(negedge clk);
    op_valid = 1'b0; md_op = 4'd0;
  endtask

  task automatic test_reset;
    op_valid = 1'b0; md_op = 4'd0; rs_val = '0; rt_val = '0; flush = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, hi, lo, start} !== {1'b0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset: busy=%b hi=%h lo=%h start=%b required 0/0/0/0", busy, hi, lo, start);
    else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_mult;
    logic s; int c;
    run_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, s, c);
    total_cnt++;
    if (s !== 1'b1) $display("FAIL mult_start: got %b required 1", s); else pass_cnt++;
    total_cnt++;
    if (c != 5) $display("FAIL mult_busy_cycles: got %0d required 5", c); else pass_cnt++;
    total_cnt++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE)
      $display("FAIL mult_result: hi=%h lo=%h required FFFFFFFF/FFFFFFFE", hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_multu;
    logic s; int c;
    run_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, s, c);
    total_cnt++;
    if (c != 5 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE)
      $display("FAIL multu: cycles=%0d hi=%h lo=%h required 5 00000001/FFFFFFFE", c, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_div;
    logic s; int c;
    run_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, s, c);
    total_cnt++;
    if (c != 10) $display("FAIL div_busy_cycles: got %0d required 10", c); else pass_cnt++;
    total_cnt++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
      $display("FAIL div_neg: hi=%h lo=%h required FFFFFFFF/FFFFFFFD", hi, lo);
    else pass_cnt++;
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, s, c);
    total_cnt++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000)
      $display("FAIL div_intmin: hi=%h lo=%h required 00000000/80000000", hi, lo);
    else pass_cnt++;
    run_op(4'd4, 32'hFFFF_FFF9, 32'h0000_0002, s, c);
    total_cnt++;
    if (hi !== 32'h0000_0001 || lo !== 32'h7FFF_FFFC)
      $display("FAIL divu: hi=%h lo=%h required 00000001/7FFFFFFC", hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_div_zero;
    logic s; int c;
    one_op(4'd5, 32'h0000_1234);
    one_op(4'd6, 32'h0000_1234);
    total_cnt++;
    if (hi !== 32'h1234 || lo !== 32'h1234)
      $display("FAIL mthi_mtlo: hi=%h lo=%h required 1234/1234", hi, lo);
    else pass_cnt++;
    run_op(4'd4, 32'h0000_0055, 32'h0, s, c);
    total_cnt++;
    if (c != 10 || hi !== 32'h1234 || lo !== 32'h1234)
      $display("FAIL divzero: cycles=%0d hi=%h lo=%h required 10 1234/1234", c, hi, lo);
    else pass_cnt++;
    op_valid = 1'b1; md_op = 4'd7;
    #1;
    total_cnt++;
    if (rd_data !== 32'h1234) $display("FAIL mfhi: got %h required 1234", rd_data); else pass_cnt++;
    // mthi then mfhi in the next cycle sees the new value
    @(negedge clk);
    md_op = 4'd5; rs_val = 32'h0000_5678;
    @(negedge clk);
    md_op = 4'd7;
    #1;
    total_cnt++;
    if (rd_data !== 32'h5678) $display("FAIL mthi_mfhi: got %h required 5678", rd_data); else pass_cnt++;
    md_op = 4'd8;
    #1;
    total_cnt++;
    if (rd_data !== 32'h1234) $display("FAIL mflo: got %h required 1234", rd_data); else pass_cnt++;
    md_op = 4'd9;
    #1;
    total_cnt++;
    if (rd_data !== 32'h0) $display("FAIL nop_rd: got %h required 0", rd_data); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || hi !== 32'h5678 || lo !== 32'h1234)
      $display("FAIL nop_state: busy=%b hi=%h lo=%h required 0 5678/1234", busy, hi, lo);
    else pass_cnt++;
    op_valid = 1'b0; md_op = 4'd0;
  endtask

  task automatic test_flush;
    @(negedge clk);
    op_valid = 1'b1; flush = 1'b1; md_op = 4'd1; rs_val = 32'd3; rt_val = 32'd4;
    #1;
    total_cnt++;
    if (start !== 1'b0) $display("FAIL flush_start: got %b required 0", start); else pass_cnt++;
    @(negedge clk);
    md_op = 4'd6; rs_val = 32'hAAAA_AAAA;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || hi !== 32'h5678 || lo !== 32'h1234)
      $display("FAIL flush_mult: busy=%b hi=%h lo=%h required 0 5678/1234", busy, hi, lo);
    else pass_cnt++;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0; md_op = 4'd0;
    total_cnt++;
    if (lo !== 32'h1234) $display("FAIL flush_mtlo: lo=%h required 1234", lo); else pass_cnt++;
  endtask

  task automatic test_reset_run;
    @(negedge clk);
    op_valid = 1'b1; md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    op_valid = 1'b0; md_op = 4'd0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL run_busy: got %b required 1", busy); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      $display("FAIL async_reset: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    int c; int c2;
    @(negedge clk);
    op_valid = 1'b1; md_op = 4'd1; rs_val = 32'd3; rt_val = 32'd4;
    @(negedge clk);
    op_valid = 1'b0; md_op = 4'd0;
    c = 0;
    while (busy && c < 50) begin
      c++;
      @(negedge clk);
    end
    // Cycle where busy just fell: new mult accepted immediately
    op_valid = 1'b1; md_op = 4'd1; rs_val = 32'd5; rt_val = 32'd6;
    #1;
    total_cnt++;
    if (c != 5 || start !== 1'b1 || hi !== 32'd0 || lo !== 32'd12)
      $display("FAIL b2b_first: cycles=%0d start=%b hi=%h lo=%h required 5 1 0/c", c, start, hi, lo);
    else pass_cnt++;
    @(negedge clk);
    md_op = 4'd5; rs_val = 32'hDEAD_BEEF;
    #1;
    total_cnt++;
    if (start !== 1'b0) $display("FAIL busy_start: got %b required 0", start); else pass_cnt++;
    c2 = 0;
    while (busy && c2 < 50) begin
      c2++;
      @(negedge clk);
      op_valid = 1'b0; md_op = 4'd0;
    end
    total_cnt++;
    if (c2 != 5 || hi !== 32'd0 || lo !== 32'd30)
      $display("FAIL b2b_second: cycles=%0d hi=%h lo=%h required 5 0/1e", c2, hi, lo);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_flush();
    test_reset_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
